bitty_exec_core: RTL and testbench
==================================

Name: bitty_exec_core

Overview:
Parametrised multi-cycle execution core for the bitty processor family. It generalises the fixed 8x16-bit datapath to NUM_REGS x DATA_W. It accepts decoded operations over a valid/ready handshake instead of a hard-wired instruction register, and talks to memory or UART glue through a req/ack port with an optional timeout. It sits between an external decoder/sequencer and the load/store unit.

Parameters:
DATA_W, 16, register/ALU width (>=8)
NUM_REGS, 8, register count (power of 2, >=2); RB = log2(NUM_REGS)
ADDR_W, 8, memory address width (<= DATA_W)
MEM_TIMEOUT, 0, cycles to wait for mem_ack before abort; 0 = wait forever

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
op_valid  in  1  operation offered
op_ready  out  1  core can accept (high only in IDLE)
op_code  in  4  operation select
op_rx  in  RB  destination / first-source register
op_ry  in  RB  second-source register
op_imm_en  in  1  1: B operand = op_imm, 0: B = R[op_ry]
op_imm  in  DATA_W  immediate
done  out  1  one-cycle completion pulse
err  out  1  valid with done; 1 = memory timeout abort
result  out  DATA_W  last C value, held until next done
mem_req  out  1  memory request, held until ack/abort
mem_we  out  1  1 = store, 0 = load; valid while mem_req
mem_addr  out  ADDR_W  B[ADDR_W-1:0]
mem_wdata  out  DATA_W  S operand (R[rx])
mem_rdata  in  DATA_W  load data, sampled on mem_ack
mem_ack  in  1  completes request; ignored when mem_req=0
dbg_sel  in  RB  debug register select
dbg_data  out  DATA_W  combinational R[dbg_sel]

Behaviour:
- Reset: state IDLE. All registers, S, B, C, result and timeout counter are 0. done=0, err=0, mem_req=0, mem_we=0. Reset mid-operation aborts without writeback and with no done pulse.
- Accept: op_valid && op_ready at an edge latches op_code, op_rx, op_ry, op_imm_en, op_imm. op_ready = (state==IDLE).
- States: IDLE -> FETCH -> EXEC -> WB -> IDLE for ALU/MOV/NOP. IDLE -> FETCH -> MEM -> WB -> IDLE for LD/ST.
- FETCH: S <= R[rx]; B <= imm_en ? imm : R[ry]. rx==ry is legal.
- EXEC: C <= f(S,B). Arithmetic is modulo 2^DATA_W and unsigned.
- op_code 0 ADD, 1 SUB (S-B), 2 AND, 3 OR, 4 XOR.
- op_code 5 SHL and 6 SHR shift S by B[log2(DATA_W)-1:0], logical.
- op_code 7 CMP: C = 0 if S==B, 1 if S>B, 2 if S<B.
- op_code 10 MOV: C = B.
- op_code 11-15 NOP: C unchanged, no writeback, done still pulses.
- MEM: mem_req=1 from state entry until the mem_ack cycle. mem_we=1 for ST (op_code 9), 0 for LD (op_code 8). The mem_* outputs are stable while mem_req=1. Ack may arrive in the first MEM cycle.
- LD captures C <= mem_rdata on ack. ST leaves C unchanged and does no register write.
- Timeout: counter counts MEM cycles without ack, including the first. When it equals MEM_TIMEOUT (nonzero), drop mem_req next edge, go to WB with err=1 and no writeback. A late mem_ack after abort is ignored.
- WB: R[rx] <= C for ALU/MOV/LD unless aborted. done=1 and result<=C for exactly this cycle. The new register value is visible on dbg_data the next cycle.
- Latency: with accept at edge T, done is high in cycle T+3 for ALU ops. For LD/ST done is high in cycle T+3+k, where k = extra MEM wait cycles.
- Throughput: ALU ops issue at one per 4 cycles. op_valid while busy is held off (ready=0); the op is not dropped.
- Operands are latched at accept; input changes after accept have no effect.

Test Plan:
- Param 16/8. Reset; MOV R1,#5; MOV R2,#7; ADD R1,R2 -> done at T+3, result=12, dbg R1=12, err=0.
- SUB R1,#13 with R1=12 -> result=0xFFFF (wrap). CMP R3,R3 -> 0. SHL 1 by #17 -> shift 1 -> 2.
- LD R4 from addr 0x2A with mem_ack 2 cycles late -> mem_req high 3 cycles, mem_addr=0x2A, mem_we=0, R4=mem_rdata, done at T+5.
- MEM_TIMEOUT=4, ST with no ack -> mem_req high 4 cycles, done with err=1, registers unchanged; a late ack is ignored.
- Reset asserted in EXEC of ADD R1 -> no done, R1=0, op_ready=1 the cycle after reset deasserts.
- Param DATA_W=8, NUM_REGS=4: ADD 0xF0+0x20 -> 0x10. op_valid held during busy -> exactly one accept per op.

Source files
------------

// File: rtl/bitty_exec_core.sv
// bitty execution core: multi-cycle FETCH/EXEC|MEM/WB datapath over a
// NUM_REGS x DATA_W register file, fed by a valid/ready op port.
module bitty_exec_core #(
    parameter  int DATA_W      = 16,
    parameter  int NUM_REGS    = 8,
    parameter  int ADDR_W      = 8,
    parameter  int MEM_TIMEOUT = 0,
    localparam int RB          = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [RB-1:0]     op_rx,
    input  logic [RB-1:0]     op_ry,
    input  logic              op_imm_en,
    input  logic [DATA_W-1:0] op_imm,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic [RB-1:0]     dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int SW = $clog2(DATA_W);
    localparam int TW = $clog2(MEM_TIMEOUT + 2);

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                           OP_XOR = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_CMP = 4'd7,
                           OP_LD  = 4'd8, OP_ST  = 4'd9, OP_MOV = 4'd10;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB} state_t;

    state_t                           r_state, w_next;
    logic [NUM_REGS-1:0][DATA_W-1:0]  r_regs;
    logic [DATA_W-1:0]                r_s, r_b, r_c, r_result, r_imm, w_alu;
    logic [3:0]                       r_code;
    logic [RB-1:0]                    r_rx, r_ry;
    logic                             r_imm_en, r_abort;
    logic [TW-1:0]                    r_tmo;
    logic [TW:0]                      w_tmo_cnt;
    logic                             w_tmo_hit, w_is_alu, w_is_mem, w_wr;

    assign w_is_alu  = (r_code <= OP_CMP) || (r_code == OP_MOV);
    assign w_is_mem  = (r_code == OP_LD) || (r_code == OP_ST);
    assign w_wr      = w_is_alu || (r_code == OP_LD);
    // MEM cycles seen so far including the current one
    assign w_tmo_cnt = {1'b0, r_tmo} + (TW+1)'(1);
    assign w_tmo_hit = (MEM_TIMEOUT != 0) && (w_tmo_cnt == (TW+1)'(MEM_TIMEOUT));

    always_comb begin
        w_alu = r_c;
        case (r_code)
            OP_ADD:  w_alu = r_s + r_b;
            OP_SUB:  w_alu = r_s - r_b;
            OP_AND:  w_alu = r_s & r_b;
            OP_OR:   w_alu = r_s | r_b;
            OP_XOR:  w_alu = r_s ^ r_b;
            OP_SHL:  w_alu = r_s << r_b[SW-1:0];
            OP_SHR:  w_alu = r_s >> r_b[SW-1:0];
            OP_CMP:  w_alu = (r_s == r_b) ? '0 : ((r_s > r_b) ? DATA_W'(1) : DATA_W'(2));
            OP_MOV:  w_alu = r_b;
            default: w_alu = r_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        op_ready = 1'b0;
        done     = 1'b0;
        mem_req  = 1'b0;
        case (r_state)
            S_IDLE:  begin
                op_ready = 1'b1;
                if (op_valid) w_next = S_FETCH;
            end
            S_FETCH: w_next = w_is_mem ? S_MEM : S_EXEC;
            S_EXEC:  w_next = S_WB;
            S_MEM:   begin
                mem_req = 1'b1;
                if (mem_ack || w_tmo_hit) w_next = S_WB;
            end
            S_WB:    begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign err       = done & r_abort;
    assign mem_we    = mem_req & (r_code == OP_ST);
    assign mem_addr  = r_b[ADDR_W-1:0];
    assign mem_wdata = r_s;
    // result tracks C during the done cycle and holds it afterwards
    assign result    = done ? r_c : r_result;
    assign dbg_data  = r_regs[dbg_sel];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_regs   <= '0;
            r_s      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_result <= '0;
            r_code   <= '0;
            r_rx     <= '0;
            r_ry     <= '0;
            r_imm_en <= 1'b0;
            r_imm    <= '0;
            r_tmo    <= '0;
            r_abort  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:  if (op_valid) begin
                    r_code   <= op_code;
                    r_rx     <= op_rx;
                    r_ry     <= op_ry;
                    r_imm_en <= op_imm_en;
                    r_imm    <= op_imm;
                    r_tmo    <= '0;
                    r_abort  <= 1'b0;
                end
                S_FETCH: begin
                    r_s <= r_regs[r_rx];
                    r_b <= r_imm_en ? r_imm : r_regs[r_ry];
                end
                S_EXEC:  r_c <= w_alu;
                S_MEM:   begin
                    if (mem_ack) begin
                        if (r_code == OP_LD) r_c <= mem_rdata;
                    end else if (w_tmo_hit) begin
                        r_abort <= 1'b1;
                    end else begin
                        r_tmo <= w_tmo_cnt[TW-1:0];
                    end
                end
                S_WB:    begin
                    r_result <= r_c;
                    if (w_wr && !r_abort) r_regs[r_rx] <= r_c;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bitty_exec_core.sv
// Random + directed bench for bitty_exec_core: a 16x8 core with a 4-cycle
// memory timeout and an 8x4 core that waits forever, both against a flat model.
module tb_bitty_exec_core;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    logic        a_valid = 0, a_ready, a_ie = 0, a_done, a_err, a_req, a_we, a_ack = 0;
    logic [3:0]  a_code = 0;
    logic [2:0]  a_rx = 0, a_ry = 0, a_dsel = 0;
    logic [15:0] a_imm = 0, a_result, a_wdata, a_rdata = 0, a_dbg;
    logic [7:0]  a_addr;

    logic        b_valid = 0, b_ready, b_ie = 0, b_done, b_err, b_req, b_we, b_ack = 0;
    logic [3:0]  b_code = 0;
    logic [1:0]  b_rx = 0, b_ry = 0, b_dsel = 0;
    logic [7:0]  b_imm = 0, b_result, b_wdata, b_rdata = 0, b_dbg, b_addr;

    bitty_exec_core #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(8), .MEM_TIMEOUT(4)) dut_a (
        .clk(clk), .reset(reset), .op_valid(a_valid), .op_ready(a_ready), .op_code(a_code),
        .op_rx(a_rx), .op_ry(a_ry), .op_imm_en(a_ie), .op_imm(a_imm), .done(a_done),
        .err(a_err), .result(a_result), .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_ack(a_ack), .dbg_sel(a_dsel),
        .dbg_data(a_dbg));

    bitty_exec_core #(.DATA_W(8), .NUM_REGS(4), .ADDR_W(8), .MEM_TIMEOUT(0)) dut_b (
        .clk(clk), .reset(reset), .op_valid(b_valid), .op_ready(b_ready), .op_code(b_code),
        .op_rx(b_rx), .op_ry(b_ry), .op_imm_en(b_ie), .op_imm(b_imm), .done(b_done),
        .err(b_err), .result(b_result), .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_ack(b_ack), .dbg_sel(b_dsel),
        .dbg_data(b_dbg));

    int n_cmp = 0, n_bad = 0;
    logic [15:0] mr [2][8];
    logic [15:0] mc [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_alu(input int code, input int s, input int b, input int w);
        int unsigned mask = (1 << w) - 1;
        int unsigned r;
        case (code)
            0:  r = s + b;
            1:  r = s - b;
            2:  r = s & b;
            3:  r = s | b;
            4:  r = s ^ b;
            5:  r = s << (b % w);
            6:  r = s >> (b % w);
            7:  r = (s == b) ? 0 : ((s > b) ? 1 : 2);
            default: r = b;
        endcase
        return 16'(r & mask);
    endfunction

    task automatic drive(input int w, input logic v, input logic [3:0] code, input int rx,
                         input int ry, input logic ie, input logic [15:0] imm);
        if (w == 0) begin
            a_valid = v; a_code = code; a_rx = 3'(rx); a_ry = 3'(ry); a_ie = ie; a_imm = imm;
        end else begin
            b_valid = v; b_code = code; b_rx = 2'(rx); b_ry = 2'(ry); b_ie = ie; b_imm = imm[7:0];
        end
    endtask

    task automatic rd_dbg(input int w, input int r, output logic [15:0] v);
        if (w == 0) begin a_dsel = 3'(r); #1 v = a_dbg; end
        else        begin b_dsel = 2'(r); #1 v = {8'h00, b_dbg}; end
    endtask

    task automatic chk_regs(input int w);
        logic [15:0] v;
        for (int r = 0; r < (w ? 4 : 8); r++) begin
            rd_dbg(w, r, v);
            chk($sformatf("dbg%0d_R%0d", w, r), v, mr[w][r]);
        end
    endtask

    task automatic run_op(input int w, input logic [3:0] code, input int rx, input int ry,
                          input logic ie, input logic [15:0] imm0, input int ackd);
        logic [15:0] mask = w ? 16'h00FF : 16'hFFFF;
        logic [15:0] imm, s, b, ec, rd, v;
        bit is_mem, abrt, wr, got;
        int nreq, lat;
        imm    = imm0 & mask;
        s      = mr[w][rx];
        b      = ie ? imm : mr[w][ry];
        is_mem = (code == 8) || (code == 9);
        abrt   = is_mem && (w == 0) && (ackd >= 4);
        rd     = 16'($urandom) & mask;
        ec     = mc[w];
        wr     = 0;
        if (code <= 7 || code == 10) begin ec = ref_alu(code, s, b, w ? 8 : 16); wr = 1; end
        else if (code == 8 && !abrt) begin ec = rd; wr = 1; end
        lat  = 3 + (is_mem ? (abrt ? 3 : ackd) : 0);
        got  = 0;
        nreq = 0;
        @(negedge clk);
        drive(w, 1, code, rx, ry, ie, imm0);
        @(posedge clk);
        #1 drive(w, 0, 4'($urandom), $urandom, $urandom, 1'($urandom), 16'($urandom));
        for (int n = 1; n <= 24 && !got; n++) begin
            @(negedge clk);
            a_rdata = 16'($urandom);
            b_rdata = 8'($urandom);
            if (w ? b_req : a_req) begin
                chk("mem_addr", w ? b_addr : a_addr, b & 16'h00FF);
                chk("mem_we", w ? b_we : a_we, code == 9);
                chk("mem_wdata", w ? {8'h0, b_wdata} : a_wdata, s);
                if (nreq == ackd) begin
                    if (w) begin b_ack = 1; b_rdata = rd[7:0]; end
                    else   begin a_ack = 1; a_rdata = rd; end
                end
                nreq++;
            end
            if (w ? b_done : a_done) begin
                got = 1;
                chk("latency", n, lat);
                chk("result", w ? {8'h0, b_result} : a_result, ec);
                chk("err", w ? b_err : a_err, abrt);
            end
            @(posedge clk);
            #1 a_ack = 0; b_ack = 0;
        end
        if (!got) chk("done_seen", 0, 1);
        chk("req_cycles", nreq, is_mem ? (abrt ? 4 : ackd + 1) : 0);
        mc[w] = ec;
        if (wr && !abrt) mr[w][rx] = ec;
        if (abrt) begin
            @(negedge clk); a_ack = 1;
            @(posedge clk); #1 a_ack = 0;
            @(negedge clk);
            chk("late_ack_done", a_done, 0);
            chk("late_ack_req", a_req, 0);
        end
        @(negedge clk);
        chk("ready_after", w ? b_ready : a_ready, 1);
        rd_dbg(w, rx, v);
        chk("dbg_rx", v, mr[w][rx]);
    endtask

    initial begin
        logic [15:0] v;
        int acc;
        for (int w = 0; w < 2; w++) begin
            mc[w] = 0;
            for (int r = 0; r < 8; r++) mr[w][r] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 0;
        chk("rst_ready", a_ready, 1);
        chk("rst_done", a_done, 0);
        chk("rst_err", a_err, 0);
        chk("rst_req", {a_req, a_we, b_req, b_we}, 0);
        chk("rst_result", a_result, 0);
        chk_regs(0);
        chk_regs(1);

        run_op(0, 10, 1, 0, 1, 16'd5, 0);
        run_op(0, 10, 2, 0, 1, 16'd7, 0);
        run_op(0, 0, 1, 2, 0, 16'h0, 0);
        run_op(0, 1, 1, 0, 1, 16'd13, 0);
        run_op(0, 7, 3, 3, 0, 16'h0, 0);
        run_op(0, 10, 5, 0, 1, 16'd1, 0);
        run_op(0, 5, 5, 0, 1, 16'd17, 0);
        run_op(0, 8, 4, 0, 1, 16'h002A, 2);
        run_op(0, 9, 4, 0, 1, 16'h0033, 9);
        run_op(0, 12, 6, 1, 0, 16'h0, 0);
        chk_regs(0);
        for (int i = 0; i < 60; i++)
            run_op(0, 4'($urandom_range(0, 15)), $urandom_range(0, 7), $urandom_range(0, 7),
                   1'($urandom), 16'($urandom), $urandom_range(0, 5));
        chk_regs(0);

        run_op(1, 10, 0, 0, 1, 16'h00F0, 0);
        run_op(1, 10, 1, 0, 1, 16'h0020, 0);
        run_op(1, 0, 0, 1, 0, 16'h0, 0);
        run_op(1, 8, 2, 0, 1, 16'h0011, 6);
        for (int i = 0; i < 40; i++)
            run_op(1, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), 16'($urandom), $urandom_range(0, 6));
        chk_regs(1);

        // op_valid held across a busy core: one accept per 4 cycles
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) drive(1, 1, 10, 1, 0, 1, 16'h003C);
            if (b_ready) acc++;
        end
        drive(1, 0, 0, 0, 0, 0, 16'h0);
        chk("held_accepts", acc, 3);
        mr[1][1] = 16'h003C;
        mc[1] = 16'h003C;
        repeat (2) @(negedge clk);
        chk("held_ready", b_ready, 1);
        chk_regs(1);

        // reset during EXEC of ADD R1,R2 must suppress writeback and done
        run_op(0, 10, 1, 0, 1, 16'h1234, 0);
        @(negedge clk);
        drive(0, 1, 0, 1, 2, 0, 16'h0);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 16'h0);
        @(negedge clk);
        chk("exec_rst_done_f", a_done, 0);
        @(negedge clk);
        chk("exec_rst_ready_e", a_ready, 0);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("exec_rst_done_r", a_done, 0);
        @(negedge clk);
        chk("exec_rst_ready", a_ready, 1);
        chk("exec_rst_done", a_done, 0);
        chk("exec_rst_result", a_result, 0);
        for (int w = 0; w < 2; w++) begin
            mc[w] = 0;
            for (int r = 0; r < 8; r++) mr[w][r] = 0;
        end
        chk_regs(0);
        run_op(0, 0, 1, 1, 1, 16'h0009, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
